psum_normalizer: RTL

PSUM_NORMALIZER -- requirements
Module: psum_normalizer

---
 rtl/psum_norm_pkg.sv | 16 +
 rtl/norm_divider.sv | 67 ++++++
 rtl/psum_normalizer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/psum_norm_pkg.sv
// Shared defaults and FSM encoding for the partial-sum normalizer and its bench.
package psum_norm_pkg;

    localparam int unsigned def_col     = 8;
    localparam int unsigned def_bw_psum = 11;
    localparam int unsigned def_sum_bw  = 18;
    localparam int unsigned def_frac    = 8;
    localparam int unsigned def_bw_norm = 12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
        StOut  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/norm_divider.sv
// Serial restoring divider: one quotient bit per clock, MSB first.
// The first bit is resolved on the start edge itself, so done rises dividend_bw-1 edges later.
module norm_divider #(
    parameter int unsigned dividend_bw = 19,
    parameter int unsigned divisor_bw  = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [dividend_bw-1:0] dividend,
    input  logic [divisor_bw-1:0]  divisor,
    output logic [dividend_bw-1:0] quotient,
    output logic                   done
);

    localparam int unsigned cnt_bw = $clog2(dividend_bw + 1);

    logic [divisor_bw-1:0]  rem_q, dvs_q;
    logic [dividend_bw-1:0] quo_q;
    logic [cnt_bw-1:0]      cnt_q;
    logic                   done_q;

    logic [divisor_bw-1:0]  src_rem, src_dvs, diff, next_rem;
    logic [dividend_bw-1:0] src_quo, next_quo;
    logic [divisor_bw:0]    shifted;
    logic                   fits, busy;

    always_comb begin
        busy    = (cnt_q != '0);
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_quo[dividend_bw-1]};
        fits    = (shifted >= {1'b0, src_dvs});
        // Remainder stays below the divisor, so the low bits hold the exact difference.
        diff     = shifted[divisor_bw-1:0] - src_dvs;
        next_rem = fits ? diff : shifted[divisor_bw-1:0];
        next_quo = {src_quo[dividend_bw-2:0], fits};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= next_rem;
            dvs_q  <= divisor;
            quo_q  <= next_quo;
            cnt_q  <= cnt_bw'(dividend_bw - 1);
            done_q <= 1'b0;
        end else if (busy) begin
            rem_q <= next_rem;
            quo_q <= next_quo;
            cnt_q <= cnt_q - cnt_bw'(1);
            if (cnt_q == cnt_bw'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/psum_normalizer.sv
// Normalizes a vector of 2*col signed psums by their absolute sum, emitting one
// saturated fixed-point element per handshake.
module psum_normalizer
    import psum_norm_pkg::*;
#(
    parameter int unsigned col     = def_col,
    parameter int unsigned bw_psum = def_bw_psum,
    parameter int unsigned sum_bw  = def_sum_bw,
    parameter int unsigned frac    = def_frac,
    parameter int unsigned bw_norm = def_bw_norm
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*bw_psum*col-1:0]   psum_in,
    input  logic [sum_bw:0]            sum_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [bw_norm-1:0]         out_data,
    output logic [3:0]                 out_idx,
    output logic                       out_last,
    output logic                       out_sat,
    output logic                       div_zero
);

    localparam int unsigned n_elem = 2 * col;
    localparam int unsigned dvd_bw = bw_psum + frac;
    localparam logic [3:0]  last_idx = 4'(n_elem - 1);
    localparam logic [dvd_bw-1:0] max_mag = dvd_bw'((2 ** (bw_norm - 1)) - 1);

    norm_state_t              state_q;
    logic [2*bw_psum*col-1:0] psum_q;
    logic [sum_bw:0]          sum_q;
    logic [3:0]               idx_q;

    logic                     accept, hs, div_start, div_done;
    logic [dvd_bw-1:0]        div_dividend, div_quo;
    logic [sum_bw:0]          div_divisor;
    logic [2*bw_psum*col-1:0] sel_vec;
    logic [3:0]               start_idx;
    logic [bw_psum-1:0]       start_elem, start_mag, cur_elem;
    logic                     q_sat;
    logic [bw_norm-2:0]       res_mag;
    logic [bw_norm-1:0]       res_data;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && (state_q == StIdle);
    assign hs       = out_valid && out_ready && (state_q == StOut);

    // The divider is launched on the same edge that accepts a vector or retires an element,
    // so the operand comes straight from the input bus on acceptance.
    always_comb begin
        sel_vec      = accept ? psum_in : psum_q;
        start_idx    = accept ? 4'd0 : idx_q + 4'd1;
        start_elem   = sel_vec[start_idx*bw_psum +: bw_psum];
        start_mag    = start_elem[bw_psum-1] ? -start_elem : start_elem;
        div_dividend = {start_mag, {frac{1'b0}}};
        div_divisor  = accept ? sum_in : sum_q;
        div_start    = (accept && (sum_in != '0))
                     || (hs && (idx_q != last_idx) && (sum_q != '0));
    end

    always_comb begin
        cur_elem = psum_q[idx_q*bw_psum +: bw_psum];
        q_sat    = (div_quo > max_mag);
        res_mag  = q_sat ? max_mag[bw_norm-2:0] : div_quo[bw_norm-2:0];
        // Negating a zero magnitude yields zero, so a zero result is never negative.
        res_data = cur_elem[bw_psum-1] ? -{1'b0, res_mag} : {1'b0, res_mag};
    end

    norm_divider #(
        .dividend_bw (dvd_bw),
        .divisor_bw  (sum_bw + 1)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            psum_q    <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        psum_q   <= psum_in;
                        sum_q    <= sum_in;
                        idx_q    <= '0;
                        div_zero <= (sum_in == '0);
                        if (sum_in == '0) begin
                            state_q   <= StOut;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_idx   <= '0;
                            out_last  <= (last_idx == 4'd0);
                            out_sat   <= 1'b0;
                        end else begin
                            state_q <= StDiv;
                        end
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state_q   <= StOut;
                        out_valid <= 1'b1;
                        out_data  <= res_data;
                        out_idx   <= idx_q;
                        out_last  <= (idx_q == last_idx);
                        out_sat   <= q_sat;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        if (idx_q == last_idx) begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            if (sum_q == '0) begin
                                out_data <= '0;
                                out_idx  <= idx_q + 4'd1;
                                out_last <= ((idx_q + 4'd1) == last_idx);
                                out_sat  <= 1'b0;
                            end else begin
                                state_q   <= StDiv;
                                out_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
